imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the processor's instruction memory. The CPU core reads that memory; this block fills it.
- Receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Drives the instruction-memory write port and holds the CPU in reset until a checksum-verified image is in place.

Parameters:
- MIPS_SIZE, 32, data word width (fixed 32; 4 bytes per word).
- ADDR_WIDTH, 8, log2 of instruction-memory depth in words; max image = 2^ADDR_WIDTH words.
- BASE_ADDR, 0, byte address of the first written word (word aligned).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RST  input  1  asynchronous, active-low reset.
- START  input  1  single-cycle request to begin a load.
- RX_DATA  input  8  incoming stream byte.
- RX_VALID  input  1  RX_DATA valid.
- RX_READY  output  1  loader accepts byte; transfer occurs when RX_VALID & RX_READY.
- WE  output  1  instruction-memory write enable, one cycle per word.
- A  output  MIPS_SIZE  instruction-memory byte address.
- WD  output  MIPS_SIZE  instruction-memory write data.
- CPU_HOLD  output  1  high keeps the CPU core in reset.
- BUSY  output  1  load in progress.
- DONE  output  1  sticky: last load succeeded.
- ERR  output  1  sticky: last load failed.
- ERR_CODE  output  2  01 = size error, 10 = checksum error, 00 = none.

Behaviour:
- Reset values (async, RST=0): state IDLE; RX_READY=0, WE=0, A=BASE_ADDR, WD=0, CPU_HOLD=0, BUSY=0, DONE=0, ERR=0, ERR_CODE=00. Internal word count, byte index and checksum are cleared.
- Frame format: CNT_HI, CNT_LO, then N=(CNT_HI<<8)|CNT_LO words of 4 bytes each, MSB first, then one CHK byte.
- CHK is the XOR of all payload bytes; header bytes are excluded from the checksum.
- States: IDLE, HDR_HI, HDR_LO, DATA, CHK, DONE, ERR.
- IDLE/DONE/ERR: RX_READY=0.
  - START=1 moves to HDR_HI next cycle, with CPU_HOLD=1, BUSY=1, DONE=0, ERR=0, ERR_CODE=00, A=BASE_ADDR, checksum=0, byte index=0.
- START while BUSY is ignored.
- HDR_HI, HDR_LO, DATA, CHK: RX_READY=1 continuously, so back-to-back bytes are accepted every cycle. Holding RX_VALID low stalls the loader indefinitely; there is no timeout.
- After HDR_LO is accepted:
  - N=0: go to CHK.
  - N > 2^ADDR_WIDTH: go to ERR with ERR_CODE=01 and no writes.
  - Otherwise: go to DATA.
- DATA: each accepted byte shifts into the word-assembly register and XORs into the checksum.
  - On the 4th byte of a word, in the cycle after acceptance: WE=1, WD=assembled word, A=current address.
  - A increments by 4 at the end of every WE cycle.
  - Byte acceptance continues during the WE cycle; the assembly register is separate from WD.
  - After the Nth word's 4th byte is accepted, go to CHK.
- CHK: on acceptance, compare the byte with the running checksum.
  - Equal: go to DONE; DONE=1 and BUSY=0. CPU_HOLD=0 one cycle after DONE rises, so the final WE completes before the CPU leaves reset.
  - Unequal: go to ERR; ERR=1, ERR_CODE=10, BUSY=0, CPU_HOLD stays 1.
- WE is asserted only in DATA-derived cycles and never in ERR or DONE.
- ERR holds CPU_HOLD=1 until a subsequent successful load or reset. A new START from DONE or ERR restarts from HDR_HI with A reset to BASE_ADDR.
- Reset mid-load returns all outputs to reset values immediately. Memory contents are not restored.
- Address arithmetic is modulo 2^MIPS_SIZE. The size check guarantees no wrap within the memory range.

Test Plan:
- Reset, then START and bytes 00 02 20 08 00 05 AC 08 00 00 89 at 1 byte/cycle -> WE pulses with (A=0x0, WD=0x20080005) and (A=0x4, WD=0xAC080000); DONE=1; CPU_HOLD falls one cycle after DONE; ERR=0.
- Same frame with CHK=0x88 -> two writes occur, then ERR=1, ERR_CODE=10, DONE=0, CPU_HOLD stays 1, BUSY=0.
- ADDR_WIDTH=8, header 01 01 (N=257) -> ERR=1, ERR_CODE=01, no WE pulse, RX_READY=0 after the header.
- Header 00 00 then CHK 00 -> no WE, DONE=1, CPU_HOLD=0.
- Valid frame with RX_VALID toggling 1-0-0-1 randomly and START pulsed mid-load -> the same two writes and DONE as the first test; the mid-load START has no effect.
- Assert RST=0 after the 5th payload byte -> all outputs take reset values asynchronously. A new START then reloads the frame from A=BASE_ADDR successfully.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: takes a framed, XOR-checksummed byte stream,
// writes big-endian 32-bit words, and keeps the CPU in reset until a good image is loaded.
module imem_loader #(
    parameter int unsigned          MIPS_SIZE  = 32,
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter logic [MIPS_SIZE-1:0] BASE_ADDR  = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [7:0]           RX_DATA,
    input  logic                 RX_VALID,
    output logic                 RX_READY,
    output logic                 WE,
    output logic [MIPS_SIZE-1:0] A,
    output logic [MIPS_SIZE-1:0] WD,
    output logic                 CPU_HOLD,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    output logic [1:0]           ERR_CODE
);

    localparam logic [31:0] MaxWords = 32'(64'd1 << ADDR_WIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StData,
        StChk,
        StDone,
        StErr
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             hdr_hi_q, hdr_hi_d;
    logic [15:0]            words_left_q, words_left_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [31:0]            asm_q, asm_d;
    logic [7:0]             chk_q, chk_d;
    logic                   we_q, we_d;
    logic [MIPS_SIZE-1:0]   a_q, a_d;
    logic [MIPS_SIZE-1:0]   wd_q, wd_d;
    logic                   hold_q, hold_d;
    logic [1:0]             err_code_q, err_code_d;
    logic                   accept;
    logic [15:0]            n_words;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= StIdle;
            hdr_hi_q     <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            chk_q        <= '0;
            we_q         <= 1'b0;
            a_q          <= BASE_ADDR;
            wd_q         <= '0;
            hold_q       <= 1'b0;
            err_code_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            hdr_hi_q     <= hdr_hi_d;
            words_left_q <= words_left_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            chk_q        <= chk_d;
            we_q         <= we_d;
            a_q          <= a_d;
            wd_q         <= wd_d;
            hold_q       <= hold_d;
            err_code_q   <= err_code_d;
        end
    end

    assign accept  = RX_VALID && RX_READY;
    assign n_words = {hdr_hi_q, RX_DATA};

    always_comb begin
        state_d      = state_q;
        hdr_hi_d     = hdr_hi_q;
        words_left_d = words_left_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        chk_d        = chk_q;
        we_d         = 1'b0;
        // Address advances after each write cycle; the next word lands one slot higher.
        a_d          = we_q ? a_q + MIPS_SIZE'(4) : a_q;
        wd_d         = wd_q;
        hold_d       = hold_q;
        err_code_d   = err_code_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                // CPU leaves reset one cycle after DONE rises, after the last write retired.
                if (state_q == StDone) hold_d = 1'b0;
                if (START) begin
                    state_d    = StHdrHi;
                    hold_d     = 1'b1;
                    err_code_d = 2'b00;
                    a_d        = BASE_ADDR;
                    chk_d      = '0;
                    byte_idx_d = '0;
                end
            end
            StHdrHi: begin
                if (accept) begin
                    hdr_hi_d = RX_DATA;
                    state_d  = StHdrLo;
                end
            end
            StHdrLo: begin
                if (accept) begin
                    words_left_d = n_words;
                    if (n_words == 16'd0) begin
                        state_d = StChk;
                    end else if ({16'd0, n_words} > MaxWords) begin
                        state_d    = StErr;
                        err_code_d = 2'b01;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    asm_d      = {asm_q[23:0], RX_DATA};
                    chk_d      = chk_q ^ RX_DATA;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d         = 1'b1;
                        wd_d         = MIPS_SIZE'({asm_q[23:0], RX_DATA});
                        words_left_d = words_left_q - 16'd1;
                        if (words_left_q == 16'd1) state_d = StChk;
                    end
                end
            end
            StChk: begin
                if (accept) begin
                    if (RX_DATA == chk_q) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StErr;
                        err_code_d = 2'b10;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        RX_READY = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        ERR      = 1'b0;
        unique case (state_q)
            StHdrHi, StHdrLo, StData, StChk: begin
                RX_READY = 1'b1;
                BUSY     = 1'b1;
            end
            StDone:  DONE = 1'b1;
            StErr:   ERR  = 1'b1;
            default: ;
        endcase
    end

    assign WE       = we_q;
    assign A        = a_q;
    assign WD       = wd_q;
    assign CPU_HOLD = hold_q;
    assign ERR_CODE = err_code_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good, bad-checksum, oversize, empty, stalled and
// reset-interrupted loads, with write pulses captured by a monitor.
module tb_imem_loader;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [7:0]  RX_DATA;
    logic        RX_VALID;
    logic        RX_READY;
    logic        WE;
    logic [31:0] A;
    logic [31:0] WD;
    logic        CPU_HOLD;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [1:0]  ERR_CODE;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    logic [7:0]  good_frame[$];
    logic [7:0]  bad_frame[$];

    imem_loader #(
        .MIPS_SIZE (32),
        .ADDR_WIDTH(8),
        .BASE_ADDR (32'h0)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .RX_DATA (RX_DATA),
        .RX_VALID(RX_VALID),
        .RX_READY(RX_READY),
        .WE      (WE),
        .A       (A),
        .WD      (WD),
        .CPU_HOLD(CPU_HOLD),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR),
        .ERR_CODE(ERR_CODE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(negedge CLK) begin
        if (WE === 1'b1) begin
            wr_a.push_back(A);
            wr_d.push_back(WD);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$], input bit gappy, input int count);
        for (int i = 0; i < count; i++) begin
            if (gappy) begin
                repeat ($urandom_range(0, 2)) begin
                    RX_VALID = 1'b0;
                    tick();
                end
            end
            RX_DATA  = bytes[i];
            RX_VALID = 1'b1;
            if (gappy && i == 5) START = 1'b1;
            tick();
            START = 1'b0;
        end
        RX_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #2;
        checks++;
        if ({RX_READY, WE, CPU_HOLD, BUSY, DONE, ERR, ERR_CODE} !== 8'h00 || A !== 32'h0 ||
            WD !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%b A=%h WD=%h, required flags=00000000 A=0 WD=0",
                     {RX_READY, WE, CPU_HOLD, BUSY, DONE, ERR, ERR_CODE}, A, WD);
        end
        RST = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        wr_a.delete();
        wr_d.delete();
        pulse_start();
        checks++;
        if (BUSY !== 1'b1 || CPU_HOLD !== 1'b1 || RX_READY !== 1'b1) begin
            errors++;
            $display("FAIL good_start: busy=%b hold=%b ready=%b, required 1 1 1",
                     BUSY, CPU_HOLD, RX_READY);
        end
        send_bytes(good_frame, 1'b0, 11);
        checks++;
        if (DONE !== 1'b1 || ERR !== 1'b0 || BUSY !== 1'b0 || CPU_HOLD !== 1'b1) begin
            errors++;
            $display("FAIL good_done: done=%b err=%b busy=%b hold=%b, required 1 0 0 1",
                     DONE, ERR, BUSY, CPU_HOLD);
        end
        tick();
        checks++;
        if (CPU_HOLD !== 1'b0 || DONE !== 1'b1) begin
            errors++;
            $display("FAIL good_release: hold=%b done=%b, required 0 1", CPU_HOLD, DONE);
        end
        checks++;
        if (wr_a.size() != 2 || wr_a[0] !== 32'h0 || wr_d[0] !== 32'h20080005 ||
            wr_a[1] !== 32'h4 || wr_d[1] !== 32'hAC080000) begin
            errors++;
            $display("FAIL good_writes: n=%0d first=%h/%h second=%h/%h, required 2 0/20080005 4/ac080000",
                     wr_a.size(), wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
        end
    endtask

    task automatic test_bad_checksum();
        wr_a.delete();
        wr_d.delete();
        pulse_start();
        send_bytes(bad_frame, 1'b0, 11);
        checks++;
        if (ERR !== 1'b1 || ERR_CODE !== 2'b10 || DONE !== 1'b0 || BUSY !== 1'b0 ||
            CPU_HOLD !== 1'b1) begin
            errors++;
            $display("FAIL chk_err: err=%b code=%b done=%b busy=%b hold=%b, required 1 10 0 0 1",
                     ERR, ERR_CODE, DONE, BUSY, CPU_HOLD);
        end
        repeat (3) tick();
        checks++;
        if (CPU_HOLD !== 1'b1 || WE !== 1'b0) begin
            errors++;
            $display("FAIL chk_hold: hold=%b we=%b, required 1 0", CPU_HOLD, WE);
        end
        checks++;
        if (wr_a.size() != 2 || wr_d[0] !== 32'h20080005 || wr_d[1] !== 32'hAC080000) begin
            errors++;
            $display("FAIL chk_writes: n=%0d, required 2 writes of the frame", wr_a.size());
        end
    endtask

    task automatic test_size_error();
        logic [7:0] hdr[$];
        hdr = '{8'h01, 8'h01};
        wr_a.delete();
        wr_d.delete();
        pulse_start();
        send_bytes(hdr, 1'b0, 2);
        checks++;
        if (ERR !== 1'b1 || ERR_CODE !== 2'b01 || RX_READY !== 1'b0 || BUSY !== 1'b0 ||
            CPU_HOLD !== 1'b1) begin
            errors++;
            $display("FAIL size_err: err=%b code=%b ready=%b busy=%b hold=%b, required 1 01 0 0 1",
                     ERR, ERR_CODE, RX_READY, BUSY, CPU_HOLD);
        end
        repeat (4) tick();
        checks++;
        if (wr_a.size() != 0) begin
            errors++;
            $display("FAIL size_nowrite: writes=%0d, required 0", wr_a.size());
        end
    endtask

    task automatic test_empty_image();
        logic [7:0] frm[$];
        frm = '{8'h00, 8'h00, 8'h00};
        wr_a.delete();
        wr_d.delete();
        pulse_start();
        checks++;
        if (ERR !== 1'b0 || ERR_CODE !== 2'b00) begin
            errors++;
            $display("FAIL empty_clear: err=%b code=%b, required 0 00", ERR, ERR_CODE);
        end
        send_bytes(frm, 1'b0, 3);
        tick();
        checks++;
        if (DONE !== 1'b1 || CPU_HOLD !== 1'b0 || ERR !== 1'b0 || wr_a.size() != 0) begin
            errors++;
            $display("FAIL empty_done: done=%b hold=%b err=%b writes=%0d, required 1 0 0 0",
                     DONE, CPU_HOLD, ERR, wr_a.size());
        end
    endtask

    task automatic test_stalls();
        wr_a.delete();
        wr_d.delete();
        pulse_start();
        send_bytes(good_frame, 1'b1, 11);
        checks++;
        if (DONE !== 1'b1 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done=%b err=%b, required 1 0", DONE, ERR);
        end
        checks++;
        if (wr_a.size() != 2 || wr_a[0] !== 32'h0 || wr_d[0] !== 32'h20080005 ||
            wr_a[1] !== 32'h4 || wr_d[1] !== 32'hAC080000) begin
            errors++;
            $display("FAIL stall_writes: n=%0d first=%h/%h second=%h/%h, required 2 0/20080005 4/ac080000",
                     wr_a.size(), wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
        end
    endtask

    task automatic test_reset_midload();
        wr_a.delete();
        wr_d.delete();
        pulse_start();
        send_bytes(good_frame, 1'b0, 7);
        checks++;
        if (A !== 32'h4 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: A=%h busy=%b, required 4 1", A, BUSY);
        end
        RST = 1'b0;
        #1;
        checks++;
        if ({RX_READY, WE, CPU_HOLD, BUSY, DONE, ERR, ERR_CODE} !== 8'h00 || A !== 32'h0 ||
            WD !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: flags=%b A=%h WD=%h, required flags=00000000 A=0 WD=0",
                     {RX_READY, WE, CPU_HOLD, BUSY, DONE, ERR, ERR_CODE}, A, WD);
        end
        #2;
        RST = 1'b1;
        tick();
        wr_a.delete();
        wr_d.delete();
        pulse_start();
        send_bytes(good_frame, 1'b0, 11);
        tick();
        checks++;
        if (DONE !== 1'b1 || CPU_HOLD !== 1'b0 || wr_a.size() != 2 || wr_a[0] !== 32'h0 ||
            wr_d[0] !== 32'h20080005 || wr_a[1] !== 32'h4 || wr_d[1] !== 32'hAC080000) begin
            errors++;
            $display("FAIL mid_reload: done=%b hold=%b writes=%0d, required 1 0 2 at 0/4",
                     DONE, CPU_HOLD, wr_a.size());
        end
    endtask

    initial begin
        RST      = 1'b1;
        START    = 1'b0;
        RX_DATA  = 8'h00;
        RX_VALID = 1'b0;
        good_frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                       8'hAC, 8'h08, 8'h00, 8'h00, 8'h89};
        bad_frame  = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                       8'hAC, 8'h08, 8'h00, 8'h00, 8'h88};
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_size_error();
        test_empty_image();
        test_stalls();
        test_reset_midload();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
